spi_nibble_master: RTL and testbench

//  SPI initiator for the 4-bit counter responder. Drives SSEL/SCK, samples MISO, rebuilds nibbles and

---
 rtl/spi_nibble_master_pkg.sv | 17 +
 rtl/spi_nibble_master_if.sv | 27 ++
 rtl/spi_nibble_master_sck_tick.sv | 24 ++
 rtl/spi_nibble_master.sv | 167 ++++++++++++++++
 tb/tb_spi_nibble_master.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_nibble_master_pkg.sv
// Shared types and constants for the SPI nibble initiator.
package spi_nibble_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_t;

  localparam logic [3:0]  FIRST_NIBBLE  = 4'hF;
  localparam logic [3:0]  SECOND_NIBBLE = 4'h7;
  localparam int unsigned BITS_PER_SLOT = 5;
  localparam int unsigned DATA_BITS     = 4;

endpackage

// File: rtl/spi_nibble_master_if.sv
// Control, status and SPI pin bundle of the nibble initiator.
interface spi_nibble_master_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] nibbles;
  logic             busy;
  logic             done;
  logic             SSEL;
  logic             SCK;
  logic             MOSI;
  logic             MISO;
  logic [3:0]       rx_data;
  logic             rx_valid;
  logic             err;
  logic [CNT_W-1:0] err_count;

  modport master (
    input  start, nibbles, MISO,
    output busy, done, SSEL, SCK, MOSI, rx_data, rx_valid, err, err_count
  );

  modport slave (
    output start, nibbles, MISO,
    input  busy, done, SSEL, SCK, MOSI, rx_data, rx_valid, err, err_count
  );
endinterface

// File: rtl/spi_nibble_master_sck_tick.sv
// Loadable down-counter; tick is high while the loaded interval has run out.
module spi_sck_tick #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/spi_nibble_master.sv
// SPI initiator reading nibbles from the 4-bit counter responder.
// Define SEQ_CHECK_EN to build the counter-sequence checker (err, err_count).
module spi_nibble_master
  import spi_nibble_pkg::*;
#(
  parameter int unsigned HALF_DIV  = 8,
  parameter int unsigned SETUP_CYC = 8,
  parameter int unsigned CNT_W     = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_nibble_master_if.master bus
);
  localparam int unsigned TW = 16;

  state_t           state;
  logic             ssel, sck, busy, done, rx_valid, fire;
  logic [3:0]       rx_data, shreg;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] nib_left;
  logic             tick, load, sample, slot_end, last_slot, accept;
  logic [TW-1:0]    load_val;

  spi_sck_tick #(.W(TW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  // MISO is captured on the edge that raises SCK, except for the turnaround slot.
  always_comb begin
    accept    = (state == IDLE) && bus.start;
    slot_end  = (bit_idx == 3'(BITS_PER_SLOT - 1));
    last_slot = slot_end && (nib_left == CNT_W'(1));
    sample    = tick && ((state == SETUP) ||
                ((state == LOW) && !last_slot && (slot_end || (bit_idx < 3'(DATA_BITS - 1)))));
    load      = 1'b0;
    load_val  = TW'(HALF_DIV);
    case (state)
      IDLE:        begin load = bus.start; load_val = TW'(SETUP_CYC); end
      SETUP, HIGH: load = tick;
      LOW:         begin load = tick; if (last_slot) load_val = TW'(SETUP_CYC); end
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ssel     <= 1'b1;
      sck      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      fire     <= 1'b0;
      rx_data  <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      nib_left <= '0;
    end else begin
      done     <= 1'b0;
      fire     <= 1'b0;
      rx_valid <= fire;
      if (fire) rx_data <= shreg;
      if (sample) shreg <= {shreg[2:0], bus.MISO};
      case (state)
        IDLE: if (accept) begin
          state    <= SETUP;
          ssel     <= 1'b0;
          busy     <= 1'b1;
          bit_idx  <= '0;
          nib_left <= (bus.nibbles == '0) ? CNT_W'(1) : bus.nibbles;
        end
        SETUP: if (tick) begin
          state <= HIGH;
          sck   <= 1'b1;
        end
        HIGH: if (tick) begin
          state <= LOW;
          sck   <= 1'b0;
          fire  <= (bit_idx == 3'(DATA_BITS - 1));
        end
        LOW: if (tick) begin
          if (last_slot) begin
            state <= HOLD;
          end else begin
            state <= HIGH;
            sck   <= 1'b1;
          end
          if (slot_end) begin
            bit_idx  <= '0;
            nib_left <= nib_left - CNT_W'(1);
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        HOLD: if (tick) begin
          state <= IDLE;
          ssel  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SSEL     = ssel;
  assign bus.SCK      = sck;
  assign bus.MOSI     = 1'b0;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;

`ifdef SEQ_CHECK_EN
  logic [3:0]       exp_nib, alt_nib;
  logic             alt_ok, first_nib, err_r, match;
  logic [CNT_W-1:0] err_cnt;

  // After a mismatch both "counter kept going" and "responder jumped" are accepted
  // next, so a single bad nibble costs exactly one error either way.
  assign match = (shreg == exp_nib) || (alt_ok && (shreg == alt_nib));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_nib   <= FIRST_NIBBLE;
      alt_nib   <= '0;
      alt_ok    <= 1'b0;
      first_nib <= 1'b1;
      err_r     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_r <= 1'b0;
      if (accept) begin
        exp_nib   <= FIRST_NIBBLE;
        alt_ok    <= 1'b0;
        first_nib <= 1'b1;
        err_cnt   <= '0;
      end else if (fire) begin
        err_r     <= !match;
        first_nib <= 1'b0;
        if (!match && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        if (first_nib) begin
          exp_nib <= SECOND_NIBBLE;
          alt_ok  <= 1'b0;
        end else if (match) begin
          exp_nib <= shreg + 4'd1;
          alt_ok  <= 1'b0;
        end else begin
          exp_nib <= exp_nib + 4'd1;
          alt_nib <= shreg + 4'd1;
          alt_ok  <= 1'b1;
        end
      end
    end
  end

  assign bus.err       = err_r;
  assign bus.err_count = err_cnt;
`else
  assign bus.err       = 1'b0;
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_spi_nibble_master.sv
// Bench for spi_nibble_master with an asynchronous counter-responder model.
`timescale 1ns/1ps
module tb_spi_nibble_master;
  localparam int HALF_DIV  = 8;
  localparam int SETUP_CYC = 8;
  localparam int CNT_W     = 8;
`ifdef SEQ_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  always #7 sclk = ~sclk;

  spi_nibble_master_if #(.CNT_W(CNT_W)) bus ();

  spi_nibble_master #(
    .HALF_DIV  (HALF_DIV),
    .SETUP_CYC (SETUP_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int flip_idx = -1;

  // Responder stream: F, 7, 8, ... mod 16, optionally with bit 1 flipped in one nibble.
  function automatic logic [3:0] stream_nibble(input int i, input int flip);
    logic [3:0] v;
    v = (i == 0) ? 4'hF : 4'((6 + i) % 16);
    if (i == flip) v = v ^ 4'b0010;
    return v;
  endfunction

  function automatic int frame_cycles(input int n);
    return 2 * SETUP_CYC + 10 * ((n == 0) ? 1 : n) * HALF_DIV;
  endfunction

  // Responder model on its own clock: SCK/SSEL resynchronised, shifts on SCK fall.
  logic [2:0] sck_sync  = '0;
  logic [1:0] ssel_sync = '1;
  int slot_pos = 0;
  int slot_idx = 0;
  always @(posedge sclk) begin
    logic [3:0] v;
    sck_sync  = {sck_sync[1:0], bus.SCK};
    ssel_sync = {ssel_sync[0], bus.SSEL};
    if (ssel_sync[1]) begin
      slot_pos = 0;
      slot_idx = 0;
    end else if (sck_sync[2] && !sck_sync[1]) begin
      if (slot_pos == 4) begin
        slot_pos = 0;
        slot_idx++;
      end else begin
        slot_pos++;
      end
    end
    v = stream_nibble(slot_idx, flip_idx);
    bus.MISO = (slot_pos < 4) ? v[3 - slot_pos] : 1'($urandom_range(0, 1));
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  logic [3:0] rx_q[$];
  logic       err_q[$];
  int unsigned rv_cyc[$];
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  int done_cnt = 0, rise_cnt = 0, err_alone = 0, sck_idle = 0, busy_cnt = 0;
  logic sck_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_q.push_back(bus.rx_data);
      err_q.push_back(bus.err);
      rv_cyc.push_back(cyc);
    end else if (bus.err) begin
      err_alone++;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy) busy_cnt++;
    if (bus.SCK && !sck_prev) rise_cnt++;
    if (bus.SSEL && bus.SCK) sck_idle++;
    sck_prev = bus.SCK;
  end

  task automatic start_frame(input int n, input int flip);
    @(posedge clk); #2;
    flip_idx = flip;
    rx_q.delete(); err_q.delete(); rv_cyc.delete();
    done_cnt = 0; rise_cnt = 0; err_alone = 0; sck_idle = 0; busy_cnt = 0;
    bus.nibbles = CNT_W'(n);
    bus.start   = 1'b1;
    start_cyc   = cyc + 1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int budget = frame_cycles(n) + 40;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #2;
      ok = (done_cnt > 0);
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    bus.start = 1'b0; bus.nibbles = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    got = {bus.SSEL, bus.SCK, bus.MOSI, bus.busy, bus.done, bus.rx_valid, bus.err, bus.rx_data, bus.err_count};
    tests++;
    if (got !== {1'b1, 6'b0, 4'h0, 8'h00}) begin
      fails++; $display("FAIL reset_outputs got=%b want=%b", got, {1'b1, 6'b0, 4'h0, 8'h00});
    end
    rst_n = 1'b1;
    rise_cnt = 0;
    repeat (20) @(posedge clk);
    #2;
    tests++;
    if ({bus.SSEL, bus.busy, rise_cnt} !== {1'b1, 1'b0, 32'd0}) begin
      fails++; $display("FAIL idle_quiet ssel=%b busy=%b rises=%0d want 1 0 0", bus.SSEL, bus.busy, rise_cnt);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [11:0] want = 12'hF78;
    start_frame(3, -1);
    tests++;
    if ({bus.busy, bus.SSEL} !== 2'b10) begin
      fails++; $display("FAIL basic_busy_ssel got=%b want=10", {bus.busy, bus.SSEL});
    end
    wait_done(3, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout done=0 want=1"); end
    tests++;
    if (rx_q.size() != 3) begin fails++; $display("FAIL basic_count got=%0d want=3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= rx_q.size() || rx_q[i] !== want[11 - 4*i -: 4]) begin
        fails++; $display("FAIL basic_rx[%0d] got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 4'hx, want[11 - 4*i -: 4]);
      end
    end
    tests++;
    if (rv_cyc.size() == 0 || (rv_cyc[0] - start_cyc) != SETUP_CYC + 7 * HALF_DIV + 1) begin
      fails++; $display("FAIL basic_latency got=%0d want=%0d", (rv_cyc.size() > 0) ? rv_cyc[0] - start_cyc : 0, SETUP_CYC + 7 * HALF_DIV + 1);
    end
    tests++;
    if (rise_cnt != 15) begin fails++; $display("FAIL basic_rises got=%0d want=15", rise_cnt); end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    tests++;
    if (int'(done_cyc - start_cyc) != frame_cycles(3) || busy_cnt != frame_cycles(3)) begin
      fails++; $display("FAIL basic_frame_len done_at=%0d busy=%0d want=%0d", done_cyc - start_cyc, busy_cnt, frame_cycles(3));
    end
    tests++;
    if ({bus.SSEL, bus.SCK, bus.busy, bus.err_count} !== {3'b100, 8'h00} || sck_idle != 0 || err_alone != 0) begin
      fails++; $display("FAIL basic_after ssel=%b sck=%b busy=%b errcnt=%0d idle_sck=%0d stray_err=%0d want 1 0 0 0 0 0",
                        bus.SSEL, bus.SCK, bus.busy, bus.err_count, sck_idle, err_alone);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    start_frame(12, -1);
    wait_done(12, ok);
    tests++;
    if (!ok || rx_q.size() != 12) begin fails++; $display("FAIL wrap_count got=%0d want=12 done=%0d", rx_q.size(), ok); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[i] !== stream_nibble(i, -1) || err_q[i] !== 1'b0) begin
        fails++; $display("FAIL wrap_rx[%0d] got=%h err=%b want=%h err=0", i, rx_q[i], err_q[i], stream_nibble(i, -1));
      end
    end
    tests++;
    if (bus.err_count !== 8'h00) begin fails++; $display("FAIL wrap_errcnt got=%0d want=0", bus.err_count); end
  endtask

  task automatic test_corrupt();
    bit ok;
    start_frame(6, 2);
    wait_done(6, ok);
    tests++;
    if (!ok || rx_q.size() != 6) begin fails++; $display("FAIL corrupt_count got=%0d want=6", rx_q.size()); end
    tests++;
    if (rx_q.size() > 3 && (rx_q[2] !== 4'hA || rx_q[3] !== 4'h9)) begin
      fails++; $display("FAIL corrupt_values got=%h,%h want=a,9", rx_q[2], rx_q[3]);
    end
    for (int i = 0; i < rx_q.size(); i++) begin
      tests++;
      if (err_q[i] !== (CHECK_ON && i == 2)) begin
        fails++; $display("FAIL corrupt_err[%0d] got=%b want=%b", i, err_q[i], CHECK_ON && i == 2);
      end
    end
    tests++;
    if (bus.err_count !== (CHECK_ON ? 8'd1 : 8'd0) || err_alone != 0) begin
      fails++; $display("FAIL corrupt_errcnt got=%0d stray=%0d want=%0d", bus.err_count, err_alone, CHECK_ON ? 1 : 0);
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    start_frame(4, -1);
    for (int i = 0; i < 200 && rx_q.size() == 0; i++) begin @(posedge clk); #2; end
    tests++;
    if (rx_q.size() == 0) begin fails++; $display("FAIL busy_first_nibble got=none want=1 nibble"); end
    bus.nibbles = CNT_W'(9);
    bus.start   = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done(4, ok);
    repeat (40) @(posedge clk);
    #2;
    tests++;
    if (!ok || done_cnt != 1 || int'(done_cyc - start_cyc) != frame_cycles(4)) begin
      fails++; $display("FAIL busy_single_done done=%0d len=%0d want 1 %0d", done_cnt, done_cyc - start_cyc, frame_cycles(4));
    end
    tests++;
    if (rise_cnt != 20 || rx_q.size() != 4 || bus.SSEL !== 1'b1) begin
      fails++; $display("FAIL busy_frame rises=%0d nibbles=%0d ssel=%b want 20 4 1", rise_cnt, rx_q.size(), bus.SSEL);
    end
    tests++;
    if (rx_q.size() > 1 && (rx_q[0] !== 4'hF || rx_q[1] !== 4'h7)) begin
      fails++; $display("FAIL busy_no_restart got=%h,%h want=f,7", rx_q[0], rx_q[1]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n, n_eff, flip;
    for (int r = 0; r < 4; r++) begin
      n     = (r == 0) ? 0 : int'($urandom_range(1, 10));
      n_eff = (n == 0) ? 1 : n;
      flip  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n_eff - 1)) : -1;
      start_frame(n, flip);
      wait_done(n, ok);
      tests++;
      if (!ok || rx_q.size() != n_eff || rise_cnt != 5 * n_eff || done_cnt != 1) begin
        fails++; $display("FAIL rand%0d_shape n=%0d got nib=%0d rises=%0d done=%0d want %0d %0d 1",
                          r, n, rx_q.size(), rise_cnt, done_cnt, n_eff, 5 * n_eff);
      end
      for (int i = 0; i < rx_q.size(); i++) begin
        tests++;
        if (rx_q[i] !== stream_nibble(i, flip) || err_q[i] !== (CHECK_ON && i == flip)) begin
          fails++; $display("FAIL rand%0d_rx[%0d] got=%h err=%b want=%h err=%b",
                            r, i, rx_q[i], err_q[i], stream_nibble(i, flip), CHECK_ON && i == flip);
        end
      end
      tests++;
      if (bus.err_count !== ((CHECK_ON && flip >= 0) ? 8'd1 : 8'd0)) begin
        fails++; $display("FAIL rand%0d_errcnt got=%0d want=%0d", r, bus.err_count, (CHECK_ON && flip >= 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_frame(3, 1);
    for (int i = 0; i < 400 && rise_cnt < 7; i++) begin @(posedge clk); #2; end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.SSEL, bus.SCK, bus.busy, bus.rx_data, bus.err_count} !== {3'b100, 4'h0, 8'h00} || rise_cnt < 7) begin
      fails++; $display("FAIL midreset_async ssel=%b sck=%b busy=%b rx=%h errcnt=%0d rises=%0d want 1 0 0 0 0 >=7",
                        bus.SSEL, bus.SCK, bus.busy, bus.rx_data, bus.err_count, rise_cnt);
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    start_frame(2, -1);
    wait_done(2, ok);
    tests++;
    if (!ok || rx_q.size() != 2 || done_cnt != 1) begin
      fails++; $display("FAIL midreset_refrm nibbles=%0d done=%0d want 2 1", rx_q.size(), done_cnt);
    end
    tests++;
    if (rx_q.size() > 1 && (rx_q[0] !== 4'hF || rx_q[1] !== 4'h7 || err_q[0] !== 1'b0 || err_q[1] !== 1'b0)) begin
      fails++; $display("FAIL midreset_seq got=%h,%h err=%b%b want=f,7 err=00", rx_q[0], rx_q[1], err_q[0], err_q[1]);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.nibbles = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_corrupt();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
